// File: rtl/dff_reg_arbiter_pkg.sv
// Purpose: shared types, state encoding and defaults for the shared-register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dff_reg_arbiter_pkg;

    // Default geometry: four requesters sharing one byte-wide register.
    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int IDX_W_DEF   = 2;

    // Sequencer states; encodings are fixed so waveforms and any
    // downstream debug decoders agree on the values.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // Modular add for requester indices; both operands are already below n,
    // so a single conditional subtract is enough.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Purpose: bundles requester, host-clear and shared-register signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: level-held REQ/CLR_REQ; GNT/ACK/CLR_DONE return the handshake.
interface dff_reg_arbiter_if
    import dff_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IDX_W   = IDX_W_DEF
);

    // Requester side
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;

    // Host clear side
    logic                     clr_req;
    logic                     clr_done;

    // Shared register side
    logic [WIDTH-1:0]         reg_q;
    logic [WIDTH-1:0]         reg_d;
    logic                     reg_load;
    logic                     reg_clr;

    // Status / readback
    logic [WIDTH-1:0]         rd_data;
    logic [IDX_W-1:0]         owner;
    logic                     busy;

    // Environment view: requesters, host and the register bank.
    modport master (
        output req, wr_data, clr_req, reg_q,
        input  gnt, ack, clr_done, reg_d, reg_load, reg_clr, rd_data, owner, busy
    );

    // Arbiter view.
    modport slave (
        input  req, wr_data, clr_req, reg_q,
        output gnt, ack, clr_done, reg_d, reg_load, reg_clr, rd_data, owner, busy
    );

endinterface

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Purpose: round-robin winner search starting at ptr (rotate, priority pick, rotate back).
// Latency: combinational, zero cycles.
// Backpressure: none; valid low when no request is asserted.
module dff_reg_arbiter_rr_pick
    import dff_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] rot;
    int                 off;

    // Rotate requests so that the pointer position lands on bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[wrap_add(i, int'(ptr), NUM_REQ)];
        end
    end

    // Lowest set bit of the rotated vector is the winner's distance from ptr;
    // adding ptr back (mod NUM_REQ) recovers the absolute index.
    always_comb begin
        valid  = 1'b0;
        off    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                off   = i;
            end
        end
        winner = IDX_W'(wrap_add(off, int'(ptr), NUM_REQ));
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one D_FF register among NUM_REQ writers plus a host clear.
// Latency: REQ sampled in IDLE -> GNT next cycle, REG_LOAD one cycle later, ACK the cycle after; clear is one cycle.
// Backpressure: requests held at level; non-owner REQ and CLR_REQ are ignored (not queued) while BUSY.
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IDX_W   = IDX_W_DEF   // must equal $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             clr_n,
    dff_reg_arbiter_if.slave bus
);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               clr_done_q, clr_done_d;
    logic [WIDTH-1:0]   reg_d_q, reg_d_d;
    logic               reg_load_q, reg_load_d;
    logic               reg_clr_q, reg_clr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [WIDTH-1:0]   owner_data;

    dff_reg_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Select the current owner's write-data slice.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_data = bus.wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = ack_q;
        clr_done_d = 1'b0;
        reg_d_d    = reg_d_q;
        reg_load_d = 1'b0;
        reg_clr_d  = 1'b0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;

        case (state_q)
            ST_IDLE: begin
                // Host clear outranks every requester.
                if (bus.clr_req) begin
                    state_d    = ST_CLEAR;
                    reg_clr_d  = 1'b1;
                    clr_done_d = 1'b1;
                end else if (pick_vld) begin
                    state_d           = ST_GRANT;
                    owner_d           = pick_idx;
                    gnt_d             = '0;
                    gnt_d[pick_idx]   = 1'b1;
                end
            end

            ST_GRANT: begin
                // Data is sampled exactly once here; later WR_DATA changes are ignored.
                reg_d_d    = owner_data;
                reg_load_d = 1'b1;
                state_d    = ST_LOAD;
            end

            ST_LOAD: begin
                // Register captures REG_D at the edge ending LOAD; acknowledge from then on.
                ack_d   = gnt_q;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                // Hold ACK until the owner releases; then advance the fairness pointer.
                if (!bus.req[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ack_d   = '0;
                    ptr_d   = IDX_W'(wrap_add(int'(owner_q), 1, NUM_REQ));
                    owner_d = '0;
                end
            end

            ST_CLEAR: begin
                // One-cycle clear pulse; the fairness pointer is left alone.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ack_d   = '0;
                owner_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, pointer and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            clr_done_q <= 1'b0;
            reg_d_q    <= '0;
            reg_load_q <= 1'b0;
            reg_clr_q  <= 1'b0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            clr_done_q <= clr_done_d;
            reg_d_q    <= reg_d_d;
            reg_load_q <= reg_load_d;
            reg_clr_q  <= reg_clr_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.clr_done = clr_done_q;
    assign bus.reg_d    = reg_d_q;
    assign bus.reg_load = reg_load_q;
    assign bus.reg_clr  = reg_clr_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    // Readback is a straight combinational copy of the shared register.
    assign bus.rd_data  = bus.reg_q;

endmodule
